// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters with a registered lookup,
// a registered mispredict pulse and a saturating mispredict count.
// Optional gshare indexing is enabled with the macro BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
  parameter int unsigned WordSize  = 32,
  parameter int unsigned IndexBits = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                fetch_valid,
  input  logic [WordSize-1:0] fetch_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  input  logic                resolve_valid,
  input  logic [WordSize-1:0] resolve_pc,
  input  logic [1:0]          resolve_cond,
  input  logic                resolve_taken,
  input  logic                resolve_pred,
  output logic                mispredict,
  output logic [15:0]         mispredict_count
);

  localparam int unsigned Entries = 1 << IndexBits;

  localparam logic [1:0] CondNone = 2'd0;
  localparam logic [1:0] CondAlu  = 2'd1;
  localparam logic [1:0] CondNalu = 2'd2;
  localparam logic [1:0] CondJump = 2'd3;

  logic [1:0]           ctr_q [Entries];
  logic [IndexBits-1:0] fetch_idx;
  logic [IndexBits-1:0] resolve_idx;
  logic                 pred_valid_q;
  logic                 pred_taken_q;
  logic                 mispredict_q;
  logic [15:0]          count_q;

  logic                 do_update;
  logic                 mispredict_d;
  logic [1:0]           ctr_cur;
  logic [1:0]           ctr_next;

  // Only the index bits of each PC feed the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[WordSize-1:IndexBits+2], fetch_pc[1:0],
                            resolve_pc[WordSize-1:IndexBits+2], resolve_pc[1:0]};

  assign do_update = resolve_valid &&
                     ((resolve_cond == CondAlu) || (resolve_cond == CondNalu));

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IndexBits-1:0] hist_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= '0;
    end else if (do_update) begin
      hist_q <= IndexBits'({hist_q, resolve_taken});
    end
  end

  // Both indices use the history as it stood before this edge's shift.
  assign fetch_idx   = fetch_pc[IndexBits+1:2] ^ hist_q;
  assign resolve_idx = resolve_pc[IndexBits+1:2] ^ hist_q;
`else
  assign fetch_idx   = fetch_pc[IndexBits+1:2];
  assign resolve_idx = resolve_pc[IndexBits+1:2];
`endif

  assign ctr_cur = ctr_q[resolve_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (resolve_taken) begin
      if (ctr_cur != 2'd3) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'd0) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    mispredict_d = 1'b0;
    if (resolve_valid) begin
      case (resolve_cond)
        CondAlu, CondNalu: mispredict_d = (resolve_taken != resolve_pred);
        CondJump:          mispredict_d = !resolve_pred;
        CondNone:          mispredict_d = 1'b0;
        default:           mispredict_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        ctr_q[i] <= 2'd1;
      end
    end else if (do_update) begin
      ctr_q[resolve_idx] <= ctr_next;
    end
  end

  // Lookup reads the pre-update counter when fetch and resolve collide.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= fetch_valid;
      if (fetch_valid) pred_taken_q <= ctr_q[fetch_idx][1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mispredict_q <= 1'b0;
      count_q      <= 16'd0;
    end else begin
      mispredict_q <= mispredict_d;
      if (mispredict_d && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign mispredict       = mispredict_q;
  assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor, plus hand sequences for reset,
// same-cycle collision, counter saturation and (when enabled) gshare indexing.
module tb_branch_predictor;

  logic        clk;
  logic        rstn;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [1:0]  resolve_cond;
  logic        resolve_taken;
  logic        resolve_pred;
  logic        mispredict;
  logic [15:0] mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(
    .WordSize (32),
    .IndexBits(4)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .resolve_valid   (resolve_valid),
    .resolve_pc      (resolve_pc),
    .resolve_cond    (resolve_cond),
    .resolve_taken   (resolve_taken),
    .resolve_pred    (resolve_pred),
    .mispredict      (mispredict),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  cond;
    logic        tk;
    logic        pr;
    logic        exp_pv;
    logic        exp_pt;
    logic        exp_mp;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic fv, input logic [31:0] fpc, input logic rv,
                     input logic [31:0] rpc, input logic [1:0] cond, input logic tk,
                     input logic pr, input logic pv, input logic pt, input logic mp,
                     input logic [15:0] cnt);
    vec_t v;
    v = '{fv, fpc, rv, rpc, cond, tk, pr, pv, pt, mp, cnt};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] rpc, input logic [1:0] cond, input logic tk,
                       input logic pr);
    fetch_valid   = fv;
    fetch_pc      = fpc;
    resolve_valid = rv;
    resolve_pc    = rpc;
    resolve_cond  = cond;
    resolve_taken = tk;
    resolve_pred  = pr;
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, pred_valid, pred_taken, mispredict, mispredict_count};
  endfunction

  function automatic logic [31:0] pack(input logic pv, input logic pt, input logic mp,
                                       input logic [15:0] cnt);
    return {13'd0, pv, pt, mp, cnt};
  endfunction

  // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic fv, input logic [31:0] fpc, input logic rv,
                      input logic [31:0] rpc, input logic [1:0] cond, input logic tk,
                      input logic pr);
    @(negedge clk);
    drive(fv, fpc, rv, rpc, cond, tk, pr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), pack(0, 0, 0, 16'd0));
    @(negedge clk);
    rstn = 1'b1;

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    //  fv fpc    rv rpc    cd tk pr   pv pt mp cnt
    add(1, 'h40, 0, 'h00, 0, 0, 0,   1, 0, 0, 16'd0);  // cold lookup: weakly not-taken
    add(0, 'h00, 0, 'h00, 0, 0, 0,   0, 0, 0, 16'd0);
    add(0, 'h00, 1, 'h40, 1, 1, 0,   0, 0, 1, 16'd1);
    add(0, 'h00, 1, 'h40, 1, 1, 0,   0, 0, 1, 16'd2);
    add(1, 'h40, 0, 'h00, 0, 0, 0,   1, 1, 0, 16'd2);  // trained to taken
    add(0, 'h00, 0, 'h00, 0, 0, 0,   0, 1, 0, 16'd2);  // pred_taken held
    add(0, 'h00, 1, 'h0C, 1, 1, 1,   0, 1, 0, 16'd2);  // index 3: five taken
    add(0, 'h00, 1, 'h0C, 1, 1, 1,   0, 1, 0, 16'd2);
    add(0, 'h00, 1, 'h0C, 1, 1, 1,   0, 1, 0, 16'd2);
    add(0, 'h00, 1, 'h0C, 1, 1, 1,   0, 1, 0, 16'd2);
    add(0, 'h00, 1, 'h0C, 1, 1, 1,   0, 1, 0, 16'd2);
    add(0, 'h00, 1, 'h0C, 2, 0, 1,   0, 1, 1, 16'd3);  // 3 -> 2
    add(1, 'h0C, 0, 'h00, 0, 0, 0,   1, 1, 0, 16'd3);
    add(0, 'h00, 1, 'h0C, 1, 0, 1,   0, 1, 1, 16'd4);  // 2 -> 1
    add(1, 'h0C, 0, 'h00, 0, 0, 0,   1, 0, 0, 16'd4);
    add(0, 'h00, 1, 'h10, 3, 1, 0,   0, 0, 1, 16'd5);  // jump, pred 0
    add(0, 'h00, 1, 'h10, 0, 1, 0,   0, 0, 0, 16'd5);  // non-branch
    add(1, 'h10, 0, 'h00, 0, 0, 0,   1, 0, 0, 16'd5);  // index 4 untouched
    add(0, 'h00, 1, 'h10, 3, 1, 1,   0, 0, 0, 16'd5);  // jump, pred 1
    add(1, 'h20, 1, 'h20, 1, 1, 0,   1, 0, 1, 16'd6);  // collision reads old value
    add(1, 'h20, 0, 'h00, 0, 0, 0,   1, 1, 0, 16'd6);  // ... but update applied

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].fv, vq[i].fpc, vq[i].rv, vq[i].rpc, vq[i].cond, vq[i].tk, vq[i].pr);
      check($sformatf("vec%0d", i), outs(),
            pack(vq[i].exp_pv, vq[i].exp_pt, vq[i].exp_mp, vq[i].exp_cnt));
    end

    // Reset asserted while a fetch and a mispredicting resolve are in flight.
    @(negedge clk);
    drive(1, 'h40, 1, 'h40, 1, 1, 0);
    #2 rstn = 1'b0;
    @(posedge clk);
    #1;
    check("midop_reset", outs(), pack(0, 0, 0, 16'd0));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;

    // Index 0 was strongly taken before reset; collision must see the reset value 1.
    step(1, 'h40, 1, 'h40, 1, 1, 0);
    check("collide_after_reset", outs(), pack(1, 0, 1, 16'd1));
    step(1, 'h40, 0, 0, 0, 0, 0);
    check("collide_update", outs(), pack(1, 1, 0, 16'd1));
`else
    // History 0 -> 0001 -> 0011 while both resolves land on entry 3.
    step(0, 0, 1, 'h0C, 1, 1, 1);
    check("gs_res1", outs(), pack(0, 0, 0, 16'd0));
    step(0, 0, 1, 'h08, 1, 1, 1);
    check("gs_res2", outs(), pack(0, 0, 0, 16'd0));
    step(1, 'h40, 0, 0, 0, 0, 0);
    check("gs_fetch_entry3", outs(), pack(1, 1, 0, 16'd0));
`endif

    // Count saturates at 16'hFFFF and mispredict keeps pulsing.
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      drive(0, 0, 1, 'h10, 3, 1, 0);
    end
    @(posedge clk);
    #1;
    check("count_saturate", outs(), pack(0, pred_taken, 1, 16'hFFFF));
    step(0, 0, 0, 0, 0, 0, 0);
    check("count_hold", {31'd0, mispredict}, 32'd0);
    check("count_hold_val", {16'd0, mispredict_count}, {16'd0, 16'hFFFF});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter WordSize, default 32, meaning the PC and word width.
REQ-002 SHALL have parameter IndexBits, default 4, giving 2^IndexBits pattern-history entries.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1: reset is asynchronous and active-low.
REQ-005 SHALL have port fetch_valid, input, 1, meaning a prediction lookup is requested this cycle.
REQ-006 SHALL have port fetch_pc, input, WordSize, meaning the PC of the instruction being fetched.
REQ-007 SHALL have port pred_valid, output, 1, meaning pred_taken is valid this cycle.
REQ-008 SHALL have port pred_taken, output, 1, meaning the predicted branch direction.
REQ-009 SHALL have port resolve_valid, input, 1, meaning a branch outcome is presented this cycle.
REQ-010 SHALL have port resolve_pc, input, WordSize, meaning the PC of the resolving branch.
REQ-011 SHALL have port resolve_cond, input, 2, meaning the branch class: 0 non-branch, 1 ALU (taken if ALU result nonzero), 2 NALU (taken if ALU result zero), 3 unconditional jump.
REQ-012 SHALL have port resolve_taken, input, 1, meaning the evaluated branch outcome.
REQ-013 SHALL have port resolve_pred, input, 1, meaning the prediction originally issued for this branch.
REQ-014 SHALL have port mispredict, output, 1, meaning a flush/redirect is required.
REQ-015 SHALL have port mispredict_count, output, 16, meaning the saturating count of mispredictions.

Function
REQ-016 SHALL hold 2^IndexBits 2-bit saturating counters; a counter value of 2 or 3 predicts taken.
REQ-017 SHALL compute the base index as pc[IndexBits+1:2].
REQ-018 SHALL register the prediction: pred_valid and pred_taken appear exactly one cycle after fetch_valid; pred_valid is 0 in cycles that follow a cycle with fetch_valid=0.
REQ-019 SHALL hold pred_taken at its last value while pred_valid=0.
REQ-020 SHALL update on resolve_valid with cond 1 or 2 only: +1 if resolve_taken, -1 otherwise, saturating at 3 and 0.
REQ-021 SHALL NOT update the table for cond 0 or 3.
REQ-022 SHALL compute the registered mispredict, one cycle after resolve_valid, as:
- cond 1/2: resolve_taken != resolve_pred
- cond 3: resolve_pred == 0
- cond 0: 0
REQ-023 SHALL hold mispredict high for exactly one cycle per mispredicted resolve.
REQ-024 SHALL increment mispredict_count in the same edge that sets mispredict, saturating at 16'hFFFF.
REQ-025 SHALL use the pre-update counter value for the prediction when a fetch and a resolve hit the same index in the same cycle; the update is still applied.
REQ-026 SHALL accept fetch and resolve every cycle, back-to-back, with no stalls.

Reset
REQ-027 SHALL, while rstn=0, set all counters to 1 (weakly not-taken) and set pred_valid=0, pred_taken=0, mispredict=0 and mispredict_count=0.
REQ-028 SHALL, on reset mid-operation, discard any in-flight prediction or resolve; no update is applied and mispredict is not raised.

Configuration
REQ-029 SHALL, with macro BRANCH_PREDICTOR_GSHARE_EN defined, keep an IndexBits-wide global history register:
- reset value 0
- shifted left with resolve_taken as LSB on every cond 1/2 resolve
- both fetch and resolve indices become base index XOR history, using the history value before that edge's shift
REQ-030 SHALL, without BRANCH_PREDICTOR_GSHARE_EN, contain no history register and use the base index unmodified.

Verification
REQ-031 SHALL cover reset then fetch_pc=0x40: the next cycle gives pred_valid=1, pred_taken=0.
REQ-032 SHALL cover two resolves, pc=0x40, cond=1, taken=1, pred=0: mispredict pulses twice, mispredict_count=2, and a subsequent fetch 0x40 predicts taken.
REQ-033 SHALL cover five taken resolves on index 3 followed by one not-taken: the counter stays at 3 then drops to 2, and the prediction stays taken.
REQ-034 SHALL cover resolve cond=3, pred=0: mispredict=1 with the table unchanged; cond=0, taken=1: no mispredict and no update.
REQ-035 SHALL cover a fetch and a resolve on pc 0x40 in the same cycle, with the counter at 1 and taken=1: the prediction is not-taken and the counter becomes 2.
REQ-036 SHALL cover, with GSHARE_EN, history=4'b0011 and fetch_pc=0x40 (base 0): the lookup reads entry 3.
